// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter for the SoC main RAM slave port.
// m0 = CPU data master, m1 = Ethernet DMA. Round-robin grant held for the
// whole bus cycle, plus a per-access watchdog that terminates a stalled
// slave access with err to the owning master.
module wb_mem_arbiter #(
    parameter int unsigned ADR_WIDTH      = 32,
    parameter int unsigned DAT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,

    input  logic [ADR_WIDTH-1:0]   m0_adr_i,
    input  logic [DAT_WIDTH-1:0]   m0_dat_i,
    output logic [DAT_WIDTH-1:0]   m0_dat_o,
    input  logic [DAT_WIDTH/8-1:0] m0_sel_i,
    input  logic                   m0_we_i,
    input  logic                   m0_cyc_i,
    input  logic                   m0_stb_i,
    output logic                   m0_ack_o,
    output logic                   m0_err_o,

    input  logic [ADR_WIDTH-1:0]   m1_adr_i,
    input  logic [DAT_WIDTH-1:0]   m1_dat_i,
    output logic [DAT_WIDTH-1:0]   m1_dat_o,
    input  logic [DAT_WIDTH/8-1:0] m1_sel_i,
    input  logic                   m1_we_i,
    input  logic                   m1_cyc_i,
    input  logic                   m1_stb_i,
    output logic                   m1_ack_o,
    output logic                   m1_err_o,

    output logic [ADR_WIDTH-1:0]   s_adr_o,
    output logic [DAT_WIDTH-1:0]   s_dat_o,
    input  logic [DAT_WIDTH-1:0]   s_dat_i,
    output logic [DAT_WIDTH/8-1:0] s_sel_o,
    output logic                   s_we_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,

    output logic                   timeout_o,
    output logic [1:0]             grant_o
);

    typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1, TIMEOUT} state_t;

    localparam logic [15:0] WD_LIMIT =
        (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic        last_m1;     // 1: m1 was the most recent owner
    logic [15:0] wd_cnt;
    logic        timeout_q;
    logic        owner_stb;
    logic        stall;
    logic        wd_fire;

    assign owner_stb = (state == OWN_M0) ? m0_stb_i :
                       (state == OWN_M1) ? m1_stb_i : 1'b0;
    assign stall     = owner_stb && !s_ack_i && !s_err_i;
    // An ack in the limit cycle removes the stall, so ack wins over timeout.
    assign wd_fire   = (TIMEOUT_CYCLES != 0) && stall && (wd_cnt == WD_LIMIT);
    assign timeout_o = timeout_q;

    // State register; reset drops any grant at the same edge.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Round-robin history, saturating stall counter and timeout pulse.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            last_m1   <= 1'b1;
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == OWN_M0) begin
                last_m1 <= 1'b0;
            end else if (state == OWN_M1) begin
                last_m1 <= 1'b1;
            end
            if (state_next != state || !stall) begin
                wd_cnt <= '0;
            end else if (wd_cnt != '1) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            timeout_q <= (state_next == TIMEOUT);
        end
    end

    // Arbitration decode and bus steering towards the current owner.
    always_comb begin
        state_next = state;
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_sel_o    = '0;
        s_we_o     = 1'b0;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        m0_dat_o   = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_dat_o   = '0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        grant_o    = 2'b00;
        unique case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = last_m1 ? OWN_M0 : OWN_M1;
                end else if (m0_cyc_i) begin
                    state_next = OWN_M0;
                end else if (m1_cyc_i) begin
                    state_next = OWN_M1;
                end
            end
            OWN_M0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i;
                grant_o  = 2'b01;
                if (!m0_cyc_i) begin
                    state_next = m1_cyc_i ? OWN_M1 : IDLE;
                end else if (wd_fire) begin
                    state_next = TIMEOUT;
                end
            end
            OWN_M1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i;
                grant_o  = 2'b10;
                if (!m1_cyc_i) begin
                    state_next = m0_cyc_i ? OWN_M0 : IDLE;
                end else if (wd_fire) begin
                    state_next = TIMEOUT;
                end
            end
            TIMEOUT: begin
                // last_m1 already names the owner whose access timed out;
                // slave ack/err are ignored here.
                if (last_m1) begin
                    m1_err_o   = 1'b1;
                    grant_o    = 2'b10;
                    state_next = m1_cyc_i ? OWN_M1 : (m0_cyc_i ? OWN_M0 : IDLE);
                end else begin
                    m0_err_o   = 1'b1;
                    grant_o    = 2'b01;
                    state_next = m0_cyc_i ? OWN_M0 : (m1_cyc_i ? OWN_M1 : IDLE);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Scoreboard bench for wb_mem_arbiter: per-master read-data queues and an
// expected grant-order queue, filled as stimulus is driven and drained by a
// monitor on every ack / new grant.
`timescale 1ns/1ps
module tb_wb_mem_arbiter;

    logic        clk;
    logic        rst_n;

    logic [31:0] m0_adr, m0_wdat, m0_rdat;
    logic [3:0]  m0_sel;
    logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
    logic [31:0] m1_adr, m1_wdat, m1_rdat;
    logic [3:0]  m1_sel;
    logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc, s_stb, s_ack, s_err;
    logic        timeout;
    logic [1:0]  grant;

    // Outputs of the instance with the watchdog disabled
    logic [31:0] nw_m0_rdat, nw_m1_rdat, nw_s_adr, nw_s_wdat;
    logic [3:0]  nw_s_sel;
    logic        nw_m0_ack, nw_m0_err, nw_m1_ack, nw_m1_err;
    logic        nw_s_we, nw_s_cyc, nw_s_stb, nw_timeout;
    logic [1:0]  nw_grant;

    int          n_checks;
    int          n_errors;
    int          gaps;
    int          slave_lat;
    logic        slave_mute;
    logic        slave_force_ack;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [1:0]  gq[$];

    wb_mem_arbiter #(.ADR_WIDTH(32), .DAT_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_ack_i(s_ack), .s_err_i(s_err),
        .timeout_o(timeout), .grant_o(grant)
    );

    wb_mem_arbiter #(.ADR_WIDTH(32), .DAT_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_nowd (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(nw_m0_rdat), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(nw_m0_ack), .m0_err_o(nw_m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(nw_m1_rdat), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(nw_m1_ack), .m1_err_o(nw_m1_err),
        .s_adr_o(nw_s_adr), .s_dat_o(nw_s_wdat), .s_dat_i(s_rdat), .s_sel_o(nw_s_sel), .s_we_o(nw_s_we),
        .s_cyc_o(nw_s_cyc), .s_stb_o(nw_s_stb), .s_ack_i(s_ack), .s_err_i(s_err),
        .timeout_o(nw_timeout), .grant_o(nw_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic ack_of(input int m);
        return (m == 0) ? m0_ack : m1_ack;
    endfunction

    task automatic drive(input int m, input logic cyc, input logic stb, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input logic we);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_adr = adr; m0_wdat = dat; m0_sel = sel; m0_we = we;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_adr = adr; m1_wdat = dat; m1_sel = sel; m1_we = we;
        end
    endtask

    // One bus cycle of 'beats' beats; stb is held low for one cycle before beat gap_beat.
    task automatic master_xfer(input int m, input logic [31:0] base, input logic [31:0] wdat,
                               input logic [3:0] sel, input logic we, input int beats, input int gap_beat);
        logic [31:0] adr;
        logic [31:0] dat;
        int          waited;
        @(posedge clk); #1;
        for (int b = 0; b < beats; b++) begin
            adr = base + 32'(b * 4);
            dat = wdat + 32'(b);
            if (b == gap_beat) begin
                drive(m, 1'b1, 1'b0, adr, dat, sel, we);
                @(posedge clk); #1;
            end
            drive(m, 1'b1, 1'b1, adr, dat, sel, we);
            if (m == 0) q0.push_back(adr + dat + 32'(sel) + 32'(we));
            else        q1.push_back(adr + dat + 32'(sel) + 32'(we));
            waited = 0;
            @(negedge clk);
            while (!ack_of(m) && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            check_eq($sformatf("m%0d_ack_seen", m), 64'(ack_of(m)), 64'd1);
            @(posedge clk); #1;
        end
        drive(m, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    // Slave memory model: read data is a mix of address, write data, sel and we.
    initial begin
        int lat_cnt;
        lat_cnt = 0;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_rdat  = '0;
        forever begin
            @(posedge clk); #2;
            s_ack  = 1'b0;
            s_rdat = '0;
            if (slave_force_ack) begin
                s_ack  = 1'b1;
                s_rdat = 32'hBAD0_BAD0;
            end else if (s_cyc && s_stb && !slave_mute) begin
                if (lat_cnt >= slave_lat) begin
                    s_ack   = 1'b1;
                    s_rdat  = s_adr + s_wdat + 32'(s_sel) + 32'(s_we);
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Monitor: drains the scoreboards on acks and new grants, counts idle gaps on handoff.
    initial begin
        logic [1:0] prev;
        prev = 2'b00;
        forever begin
            @(negedge clk);
            if (m0_ack) begin
                check_eq("m0_sb_pending", 64'(q0.size() != 0), 64'd1);
                if (q0.size() != 0) check_eq("m0_rdat", 64'(m0_rdat), 64'(q0.pop_front()));
                check_eq("m0_ack_grant", 64'(grant), 64'd1);
                check_eq("m1_quiet", 64'({m1_ack, m1_err, m1_rdat}), 64'd0);
            end
            if (m1_ack) begin
                check_eq("m1_sb_pending", 64'(q1.size() != 0), 64'd1);
                if (q1.size() != 0) check_eq("m1_rdat", 64'(m1_rdat), 64'(q1.pop_front()));
                check_eq("m1_ack_grant", 64'(grant), 64'd2);
                check_eq("m0_quiet", 64'({m0_ack, m0_err, m0_rdat}), 64'd0);
            end
            if (grant != prev && grant != 2'b00) begin
                check_eq("grant_pending", 64'(gq.size() != 0), 64'd1);
                if (gq.size() != 0) check_eq("grant_order", 64'(grant), 64'(gq.pop_front()));
            end
            if (grant == 2'b00 && ((prev == 2'b01 && m1_cyc) || (prev == 2'b10 && m0_cyc)))
                gaps++;
            prev = grant;
        end
    end

    initial begin
        int errs_seen;
        n_checks        = 0;
        n_errors        = 0;
        gaps            = 0;
        slave_lat       = 0;
        slave_mute      = 1'b0;
        slave_force_ack = 1'b0;
        rst_n           = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_ctrl", 64'({grant, s_cyc, s_stb, s_we, s_sel, timeout,
                                    m0_ack, m0_err, m1_ack, m1_err}), 64'd0);
        check_eq("reset_bus", 64'({s_adr, s_wdat}), 64'd0);
        check_eq("reset_rdat", 64'({m0_rdat, m1_rdat}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single master read, slave acks two cycles after seeing stb
        slave_lat = 2;
        gq.push_back(2'b01);
        fork
            master_xfer(0, 32'hDEADBEEF, 32'h0, 4'h0, 1'b0, 1, -1);
            begin
                @(posedge clk);
                @(negedge clk);
                check_eq("arb_lat_grant", 64'(grant), 64'd0);
                check_eq("arb_lat_stb", 64'(s_stb), 64'd0);
                @(negedge clk);
                check_eq("single_grant", 64'(grant), 64'd1);
                check_eq("single_ack_t0", 64'(m0_ack), 64'd0);
                @(negedge clk);
                check_eq("single_ack_t1", 64'(m0_ack), 64'd0);
                @(negedge clk);
                check_eq("single_ack_t2", 64'({m0_ack, m0_rdat}), 64'({1'b1, 32'hDEADBEEF}));
            end
        join

        // Tie after reset: m0 first, then m1 with no idle cycle
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        slave_lat = 1;
        gq.push_back(2'b01);
        gq.push_back(2'b10);
        fork
            master_xfer(0, 32'h0000_0100, 32'h11, 4'hF, 1'b1, 1, -1);
            master_xfer(1, 32'h0000_0200, 32'h22, 4'h3, 1'b0, 2, -1);
        join

        // Round robin under continuous contention: 8 single-beat transfers
        repeat (3) @(posedge clk);
        slave_lat = 0;
        for (int i = 0; i < 4; i++) begin
            gq.push_back(2'b01);
            gq.push_back(2'b10);
        end
        fork
            for (int i = 0; i < 4; i++)
                master_xfer(0, 32'h1000 + 32'(i * 16), 32'h100 + 32'(i), 4'h5, 1'b0, 1, -1);
            for (int i = 0; i < 4; i++)
                master_xfer(1, 32'h2000 + 32'(i * 16), 32'h200 + 32'(i), 4'hA, 1'b1, 1, -1);
        join
        check_eq("handoff_gaps", 64'(gaps), 64'd0);

        // Block hold: m1 4-beat burst with stb low before beat 2, m0 waits
        repeat (3) @(posedge clk);
        slave_lat = 1;
        gq.push_back(2'b10);
        gq.push_back(2'b01);
        fork
            master_xfer(1, 32'h3000, 32'h40, 4'hF, 1'b1, 4, 1);
            begin
                repeat (2) @(posedge clk);
                master_xfer(0, 32'h4000, 32'h50, 4'hC, 1'b0, 1, -1);
            end
        join
        check_eq("burst_gaps", 64'(gaps), 64'd0);

        // Watchdog, limit 4: err/timeout exactly 4 cycles after stb reaches the slave
        repeat (3) @(posedge clk);
        slave_mute = 1'b1;
        gq.push_back(2'b01);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h5000, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        check_eq("wd_stb_hidden", 64'(s_stb), 64'd0);
        @(negedge clk);
        check_eq("wd_stb_seen", 64'({s_stb, m0_err, timeout}), 64'b100);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check_eq($sformatf("wd_quiet_%0d", k), 64'({m0_err, timeout, s_cyc}), 64'b001);
        end
        @(negedge clk);
        check_eq("wd_fire", 64'({m0_err, m1_err, timeout, s_cyc, s_stb}), 64'b10100);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);

        // Watchdog disabled: 1000 stalled cycles, no err
        repeat (3) @(posedge clk);
        gq.push_back(2'b01);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h5100, 32'h0, 4'hF, 1'b0);
        errs_seen = 0;
        repeat (1000) begin
            @(negedge clk);
            if (nw_m0_err || nw_timeout) errs_seen++;
        end
        check_eq("nowd_err_count", 64'(errs_seen), 64'd0);
        check_eq("nowd_grant", 64'({nw_grant, nw_s_cyc, nw_s_stb}), 64'b0111);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);

        // Reset while m1 owns with stb high
        repeat (3) @(posedge clk);
        gq.push_back(2'b10);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 32'h6000, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_pre_grant", 64'({grant, s_stb}), 64'b101);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        slave_force_ack = 1'b1;
        @(negedge clk);
        check_eq("rst_drop", 64'({grant, s_cyc, s_stb}), 64'd0);
        check_eq("rst_late_ack0", 64'({m1_ack, m1_err, m1_rdat}), 64'd0);
        @(negedge clk);
        check_eq("rst_late_ack1", 64'({m1_ack, m1_err, m1_rdat}), 64'd0);
        @(posedge clk); #1;
        slave_force_ack = 1'b0;
        rst_n = 1'b1;
        gq.push_back(2'b01);
        drive(0, 1'b1, 1'b1, 32'h7000, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        check_eq("rst_tie_idle", 64'(grant), 64'd0);
        @(negedge clk);
        check_eq("rst_tie_m0", 64'(grant), 64'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("sb_drained", 64'(gq.size() + q0.size() + q1.size()), 64'd0);
        check_eq("final_gaps", 64'(gaps), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
